// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions used by both the instruction encoder (program-load
// path) and the instruction decoder.
//   - opcode constants for the supported instruction classes
//   - instr_fmt_t : encoding format selected from opcode/funct3
//   - enc_state_t : load-sequencer states of the encoder
//   - NOP_INSTR   : addi x0,x0,0, written in place of an illegal instruction
//   - instr_fmt() : opcode/funct3 -> format classification
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OP_RALU     = 7'b0110011;
    localparam logic [6:0] OP_IALU     = 7'b0010011;
    localparam logic [6:0] OP_SBBRANCH = 7'b1100011;
    localparam logic [6:0] OP_IJUMP    = 7'b1100111;
    localparam logic [6:0] OP_UJJUMP   = 7'b1101111;
    localparam logic [6:0] OP_ILOAD    = 7'b0000011;
    localparam logic [6:0] OP_SSTORE   = 7'b0100011;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_ISH = 3'd2,
        FMT_S   = 3'd3,
        FMT_SB  = 3'd4,
        FMT_UJ  = 3'd5,
        FMT_BAD = 3'd6
    } instr_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    // Shift-immediate ALU ops (slli/srli/srai) carry funct7 above a 5-bit shamt.
    function automatic instr_fmt_t instr_fmt(input logic [6:0] op, input logic [2:0] f3);
        instr_fmt_t fmt;
        case (op)
            OP_RALU:     fmt = FMT_R;
            OP_IALU:     fmt = ((f3 == 3'b001) || (f3 == 3'b101)) ? FMT_ISH : FMT_I;
            OP_ILOAD:    fmt = FMT_I;
            OP_IJUMP:    fmt = FMT_I;
            OP_SSTORE:   fmt = FMT_S;
            OP_SBBRANCH: fmt = FMT_SB;
            OP_UJJUMP:   fmt = FMT_UJ;
            default:     fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered full/empty flags. The head entry is
// presented on head_data whenever empty=0. Storage is cleared by reset so the
// head output reads zero after reset.
// Ports:
//   clock, nReset      : rising-edge clock, asynchronous active-low reset
//   push, push_data    : write request (ignored when full)
//   pop                : remove head entry (ignored when empty)
//   head_data          : oldest stored entry
//   full, empty        : occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & ~full_q;
    assign pop_ok_s  = pop  & ~empty_q;

    // Pointer/occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push_ok_s};
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_ok_s};
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == {CW{1'b0}});
    end

    // Control registers.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Packs RV32I fields into 32-bit instruction words and writes them to
// consecutive instruction-memory addresses (program-load path).
// Ports:
//   clock, nReset         : rising-edge clock, asynchronous active-low reset
//   start, base_addr,count: begin a load of `count` words at `base_addr`
//   in_valid/in_ready     : field-bundle handshake
//   opcode..imm           : instruction fields (imm sign-extended, byte offset)
//   mem_we/addr/wdata     : memory write port, held until mem_ready
//   busy, done, err       : load status; err is sticky until next start
// ---------------------------------------------------------------------------
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          nReset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] count,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [6:0]    opcode,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [31:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    enc_state_t    state_q,    state_d;
    logic [AW-1:0] total_q,    total_d;
    logic [AW-1:0] accepted_q, accepted_d;
    logic [AW-1:0] written_q,  written_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic          err_q,      err_d;
    logic          done_q,     done_d;
    logic          busy_q,     busy_d;

    instr_fmt_t    fmt_s;
    logic [31:0]   enc_word_s;
    logic          enc_err_s;
    logic          start_ok_s;
    logic          xfer_s;
    logic          wr_hs_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [31:0]   fifo_head_s;
    logic          unused_imm_s;

    // Upper immediate bits are sign extension that no format consumes.
    assign unused_imm_s = ^imm[31:21];

    // Field packer: pure function of the current input bundle.
    always_comb begin
        fmt_s      = instr_fmt(opcode, funct3);
        enc_word_s = NOP_INSTR;
        enc_err_s  = 1'b0;
        case (fmt_s)
            FMT_R:   enc_word_s = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   enc_word_s = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_ISH: enc_word_s = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            FMT_S:   enc_word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_SB: begin
                // Branch offsets are halfword aligned; a set bit 0 is dropped and flagged.
                enc_word_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err_s  = imm[0];
            end
            FMT_UJ: begin
                enc_word_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err_s  = imm[0];
            end
            default: begin
                enc_word_s = NOP_INSTR;
                enc_err_s  = 1'b1;
            end
        endcase
    end

    assign start_ok_s = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign in_ready   = (state_q == ST_RUN) & ~fifo_full_s & (accepted_q < total_q);
    assign xfer_s     = in_valid & in_ready;
    assign mem_we     = ~fifo_empty_s;
    assign wr_hs_s    = mem_we & mem_ready;

    // Encoded words queue up between the input handshake and the memory port.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .nReset    (nReset),
        .push      (xfer_s),
        .push_data (enc_word_s),
        .pop       (wr_hs_s),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Load sequencer, counters and status next-state.
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        accepted_d = accepted_q;
        written_d  = written_q;
        addr_d     = addr_q;
        err_d      = err_q;

        if (start_ok_s) begin
            total_d    = count;
            accepted_d = {AW{1'b0}};
            written_d  = {AW{1'b0}};
            addr_d     = base_addr;
        end else begin
            accepted_d = accepted_q + {{(AW-1){1'b0}}, xfer_s};
            written_d  = written_q  + {{(AW-1){1'b0}}, wr_hs_s};
            addr_d     = addr_q     + {{(AW-1){1'b0}}, wr_hs_s};
        end

        if (start_ok_s) begin
            err_d = 1'b0;
        end else if (xfer_s && enc_err_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        // Completion looks at written_d so done rises the cycle after the last write.
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) state_d = ST_RUN;
                else            state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (accepted_q == total_q) begin
                    if (written_d == total_q) state_d = ST_DONE;
                    else                      state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (written_d == total_q) state_d = ST_DONE;
                else                      state_d = ST_DRAIN;
            end
            ST_DONE: begin
                if (start_ok_s) state_d = ST_RUN;
                else            state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) | (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and status registers.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            total_q    <= {AW{1'b0}};
            accepted_q <= {AW{1'b0}};
            written_q  <= {AW{1'b0}};
            addr_q     <= {AW{1'b0}};
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            accepted_q <= accepted_d;
            written_q  <= written_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = fifo_head_s;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
